fp_mul_round: RTL and testbench
===============================

FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 Parameters: none; all widths SHALL be fixed for IEEE-754 single precision.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream product beat valid.
REQ-005 in_ready  output  1  stage can accept a beat this cycle.
REQ-006 in_sign  input  1  result sign (sign_a XOR sign_b).
REQ-007 in_exp  input  10  two's-complement exponent ea+eb-127, before normalization.
REQ-008 in_prod  input  48  unsigned mantissa product, from the 25x25 Booth multiplier's p[47:0].
REQ-009 in_nan, in_inf, in_zero  input  1 each  special-operand class, resolved upstream (inf*0 arrives as in_nan).
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_result  output  32  packed single-precision result.
REQ-013 out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-014 The block SHALL be a 2-stage pipeline: S1 normalizes; S2 rounds, range-checks and packs. Latency in_valid&in_ready -> out_valid SHALL be exactly 2 cycles with no stall.
REQ-015 Transfer occurs when valid&ready on the same edge; out_result/out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 S2 load enable = !out_valid | out_ready; S1 load enable = !s1_valid | S2 enable; in_ready SHALL equal S1 enable, combinational, with no combinational path from in_valid.
REQ-017 Full throughput: with out_ready held 1, one beat SHALL be accepted and one retired every cycle.
REQ-018 Normalize, in_prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=in_exp+1.
REQ-019 Normalize, in_prod[47]=0: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=in_exp.
REQ-020 Rounding SHALL be round-to-nearest-even: increment when guard & (sticky | mant[0]); inexact = guard | sticky.
REQ-021 A rounding carry out of 23 bits SHALL set mant=0 and exp+=1.
REQ-022 Final exp >= 255: result {sign,8'hFF,23'h0}; overflow=1, inexact=1.
REQ-023 Final exp <= 0: flush to signed zero {sign,31'h0}; underflow=1, inexact=1; no subnormals produced.
REQ-024 Special precedence SHALL be nan > inf > zero: nan -> 32'h7FC00000; inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; all flags 0 for specials; in_prod ignored.
REQ-025 Exponent arithmetic SHALL use at least 10-bit signed width; no intermediate wrap-around.
REQ-026 Beats SHALL retire in acceptance order; none dropped or duplicated under any out_ready pattern.

Reset
REQ-027 rst=1 at a clock edge SHALL clear both stage valids; out_valid=0, out_result=32'h0, out_flags=3'b000.
REQ-028 in_ready SHALL be 1 in the cycle after reset is released.
REQ-029 Beats in flight when rst asserts SHALL be discarded; rst has priority over simultaneous in_valid/out_ready.

Verification
REQ-030 1.0x1.0: prod=48'h4000_0000_0000, exp=127, sign=0 -> 32'h3F800000, flags 000, out_valid exactly 2 cycles after accept.
REQ-031 1.5x1.5: prod=48'h9000_0000_0000, exp=127 -> 32'h40100000, flags 000; sign=1 -> 32'hC0100000.
REQ-032 Rounding: prod=2^46+2^22 -> 32'h3F800000, flags 001 (tie to even); prod=2^46+2^23+2^22 -> 32'h3F800002, flags 001; prod=48'h7FFF_FFFF_FFFF, exp=127 -> 32'h40000000 (mant carry), flags 001.
REQ-033 Range: exp=254, prod=48'hFFFF_FFFF_FFFF -> 32'h7F800000, flags 101; exp=0, prod=2^46 -> 32'h00000000, flags 011; in_nan=1 with in_inf=1 -> 32'h7FC00000, flags 000.
REQ-034 Backpressure: out_ready=0 for 4 cycles while 4 beats are offered -> 2 accepted, in_ready=0 afterwards, output held stable; on release, all 4 retire in order, back-to-back.
REQ-035 Reset mid-stream: rst pulsed with both stages full -> out_valid=0 next cycle, no stale beat emitted, in_ready=1 after release.

Source files
------------

// File: rtl/fp_mul_round.sv
// fp_mul_round: normalize / round / pack stage that follows a single-precision
// mantissa multiplier. Two pipeline stages with valid/ready handshaking:
//   S1 normalizes the 48-bit product into mantissa, guard and sticky bits.
//   S2 rounds to nearest-even, range-checks the exponent and packs the result.
module fp_mul_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  // ---------------------------------------------------------------- control
  logic w_s2_en;
  logic w_s1_en;

  // Exponents are carried 12 bits wide and signed so that in_exp+1 plus a
  // rounding carry can never wrap, whatever the 10-bit input holds.
  logic               r_s1_valid;
  logic               r_s1_sign;
  logic signed [11:0] r_s1_exp;
  logic [22:0]        r_s1_mant;
  logic               r_s1_guard;
  logic               r_s1_sticky;
  logic               r_s1_nan;
  logic               r_s1_inf;
  logic               r_s1_zero;

  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic [2:0]         r_out_flags;

  // S2 advances when its slot is empty or being drained; S1 when it is empty
  // or S2 advances. in_ready depends only on registered state and out_ready.
  assign w_s2_en  = !r_out_valid | out_ready;
  assign w_s1_en  = !r_s1_valid | w_s2_en;
  assign in_ready = w_s1_en;

  // -------------------------------------------------------------- normalize
  logic               w_top;
  logic [22:0]        w_norm_mant;
  logic               w_norm_guard;
  logic               w_norm_sticky;
  logic signed [11:0] w_norm_exp;

  assign w_top         = in_prod[47];
  assign w_norm_mant   = w_top ? in_prod[46:24] : in_prod[45:23];
  assign w_norm_guard  = w_top ? in_prod[23]    : in_prod[22];
  assign w_norm_sticky = w_top ? (|in_prod[22:0]) : (|in_prod[21:0]);
  assign w_norm_exp    = $signed({{2{in_exp[9]}}, in_exp}) + $signed({11'd0, w_top});

  // S1 register: capture the normalized beat whenever the stage may load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_mant   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_zero   <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_sign;
        r_s1_exp    <= w_norm_exp;
        r_s1_mant   <= w_norm_mant;
        r_s1_guard  <= w_norm_guard;
        r_s1_sticky <= w_norm_sticky;
        r_s1_nan    <= in_nan;
        r_s1_inf    <= in_inf;
        r_s1_zero   <= in_zero;
      end
    end
  end

  // ---------------------------------------------------------- round & pack
  logic               w_round_up;
  logic [23:0]        w_mant_sum;
  logic               w_carry;
  logic [22:0]        w_final_mant;
  logic signed [11:0] w_final_exp;
  logic [31:0]        w_result;
  logic [2:0]         w_flags;

  assign w_round_up   = r_s1_guard & (r_s1_sticky | r_s1_mant[0]);
  assign w_mant_sum   = {1'b0, r_s1_mant} + {23'd0, w_round_up};
  assign w_carry      = w_mant_sum[23];
  // A carry means the fraction rolled over to exactly 1.0 of the next binade
  assign w_final_mant = w_carry ? 23'd0 : w_mant_sum[22:0];
  assign w_final_exp  = r_s1_exp + $signed({11'd0, w_carry});

  // Select special, overflow, underflow or normal packing; specials win
  always_comb begin
    w_result = {r_s1_sign, w_final_exp[7:0], w_final_mant};
    w_flags  = {2'b00, r_s1_guard | r_s1_sticky};
    if (r_s1_nan) begin
      w_result = 32'h7FC0_0000;
      w_flags  = 3'b000;
    end else if (r_s1_inf) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 3'b000;
    end else if (r_s1_zero) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 3'b000;
    end else if (w_final_exp >= 12'sd255) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 3'b101;
    end else if (w_final_exp <= 12'sd0) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 3'b011;
    end
  end

  // S2 register: output holds steady until the downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_flags  <= 3'b000;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_result;
        r_out_flags  <= w_flags;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fp_mul_round.sv
// Bench for fp_mul_round: table of directed vectors with hand-computed
// results, plus backpressure and mid-stream reset sequences.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_prod = '0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  fp_mul_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_prod   (in_prod),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[18];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, expv);
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign;
    in_exp  = v.exp;
    in_prod = v.prod;
    in_nan  = v.nan;
    in_inf  = v.inf;
    in_zero = v.zero;
  endtask

  // Hard time limit so the bench can never hang
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, ret, gaps, stale;
    logic ok;
    int bp[4];

    vecs[0]  = '{"one_x_one",     1'b0, 10'd127,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[1]  = '{"1p5_sq",        1'b0, 10'd127,  48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000};
    vecs[2]  = '{"1p5_sq_neg",    1'b1, 10'd127,  48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hC010_0000, 3'b000};
    vecs[3]  = '{"tie_even",      1'b0, 10'd127,  48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001};
    vecs[4]  = '{"tie_odd_up",    1'b0, 10'd127,  48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001};
    vecs[5]  = '{"mant_carry",    1'b0, 10'd127,  48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001};
    vecs[6]  = '{"overflow",      1'b0, 10'd254,  48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};
    vecs[7]  = '{"underflow_e0",  1'b0, 10'd0,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011};
    vecs[8]  = '{"nan_over_inf",  1'b1, 10'd127,  48'h1234_5678_9ABC, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000};
    vecs[9]  = '{"inf_over_zero", 1'b1, 10'd3,    48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFF80_0000, 3'b000};
    vecs[10] = '{"zero_neg",      1'b1, 10'd200,  48'h9000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000};
    vecs[11] = '{"min_normal",    1'b0, 10'd1,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000};
    vecs[12] = '{"carry_to_ovf",  1'b0, 10'd253,  48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};
    vecs[13] = '{"exp_max_nowrap",1'b0, 10'h1FF,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};
    vecs[14] = '{"exp_min_nowrap",1'b1, 10'h200,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011};
    vecs[15] = '{"sticky_only",   1'b0, 10'd127,  48'h4000_0000_0001, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001};
    vecs[16] = '{"top_tie_odd",   1'b0, 10'd126,  48'h8000_0180_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001};
    vecs[17] = '{"neg_exp_to_0",  1'b0, 10'h3FF,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011};

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", out_result, 32'd0);
    check("reset_flags", {29'd0, out_flags}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // ---- table: one beat each, checking 2-cycle latency and the packed value
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_lat1"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check({vecs[i].name, "_lat2"}, {31'd0, out_valid}, 32'd1);
      check({vecs[i].name, "_result"}, out_result, vecs[i].res);
      check({vecs[i].name, "_flags"}, {29'd0, out_flags}, {29'd0, vecs[i].flags});
      $display("vec %0d %s: result=%08h flags=%03b", i, vecs[i].name, out_result, out_flags);
    end

    // ---- backpressure: 4 beats offered while the output is stalled
    bp[0] = 1; bp[1] = 3; bp[2] = 6; bp[3] = 9;
    acc = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) begin
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_result", out_result, vecs[bp[0]].res);
      end
      drive(vecs[bp[acc]]);
      in_valid = 1'b1;
      #1 ok = in_ready;
      @(posedge clk);
      if (ok) acc++;
    end
    @(negedge clk);
    check("bp_accepted", acc, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_held_result", out_result, vecs[bp[0]].res);
    check("bp_held_flags", {29'd0, out_flags}, {29'd0, vecs[bp[0]].flags});
    $display("backpressure: accepted=%0d while stalled", acc);

    out_ready = 1'b1;
    ret = 0;
    gaps = 0;
    for (int c = 0; c < 20 && ret < 4; c++) begin
      if (out_valid) begin
        check("bp_retire_order", out_result, vecs[bp[ret]].res);
        $display("retire %0d: result=%08h", ret, out_result);
        ret++;
      end else if (ret > 0) begin
        gaps++;
      end
      if (acc < 4) begin
        drive(vecs[bp[acc]]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1 ok = in_ready & in_valid;
      @(posedge clk);
      if (ok) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_all_retired", ret, 32'd4);
    check("bp_back_to_back", gaps, 32'd0);

    // ---- reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4 && acc < 2; c++) begin
      if (c > 0) @(negedge clk);
      drive(vecs[acc]);
      in_valid = 1'b1;
      #1 ok = in_ready;
      @(posedge clk);
      if (ok) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_full_valid", {31'd0, out_valid}, 32'd1);
    check("rst_pre_full_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    drive(vecs[4]);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {29'd0, out_flags}, 32'd0);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 32'd0);
    $display("reset mid-stream: stale beats=%0d", stale);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
